// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the architectural PC and keeps one imem request in flight.
// It presents {pc, cmd, fault} to the core over valid/ready and accepts redirects from the core.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_CMD  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_cmd,
  output logic        inst_fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        drop;
  logic        misaligned;
  logic        req_fire;

  function automatic logic [31:0] seq_pc(input logic [31:0] cur);
    return cur + 32'd4;
  endfunction

  assign misaligned     = (pc[1:0] != 2'b00);
  assign imem_req_valid = (state == S_REQ) && !misaligned;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst_cmd   <= NOP_CMD;
      inst_pc    <= 32'd0;
      inst_fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            // A request accepted in the redirect cycle still owes a response; discard it.
            if (req_fire) begin
              state <= S_WAIT;
              drop  <= 1'b1;
            end
          end else if (misaligned) begin
            state      <= S_OUT;
            inst_valid <= 1'b1;
            inst_fault <= 1'b1;
            inst_cmd   <= NOP_CMD;
            inst_pc    <= pc;
          end else if (req_fire) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            if (imem_resp_valid) begin
              state <= S_REQ;
              drop  <= 1'b0;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              state      <= S_OUT;
              inst_valid <= 1'b1;
              inst_cmd   <= imem_resp_data;
              inst_fault <= imem_resp_err;
              inst_pc    <= pc;
            end
          end
        end

        S_OUT: begin
          // Redirect beats a same-cycle consume: the instruction is squashed, no pc+4.
          if (redirect_valid) begin
            pc         <= redirect_pc;
            state      <= S_REQ;
            inst_valid <= 1'b0;
            inst_cmd   <= NOP_CMD;
            inst_fault <= 1'b0;
          end else if (inst_ready) begin
            pc         <= seq_pc(pc);
            state      <= S_REQ;
            inst_valid <= 1'b0;
            inst_cmd   <= NOP_CMD;
            inst_fault <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: a PC-sequence reference model plus a queued memory model
// with address-derived data/error, random stalls, redirects and asynchronous resets.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_CMD  = 32'h0000_0013;
  localparam int          N_CYC    = 6000;
  localparam int          N_DIR    = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_cmd;
  logic        inst_fault;

  ifu_fetch #(.RESET_PC(RESET_PC), .NOP_CMD(NOP_CMD)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_cmd(inst_cmd), .inst_fault(inst_fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[6:2] == 5'h02;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_cmd"}, inst_cmd, NOP_CMD);
    chk({tag, "_pc"}, inst_pc, 32'd0);
    chk({tag, "_fault"}, {31'd0, inst_fault}, 32'd0);
    chk({tag, "_req"}, {31'd0, imem_req_valid}, 32'd0);
  endtask

  // reference model state
  logic [31:0] exp_pc;
  logic [31:0] q_addr[$];
  int          q_dly[$];
  logic        exp_inv_next;
  logic        prev_req_stall;
  logic        prev_valid;
  logic        guard;
  logic        directed;
  logic        fire;
  logic        hs;
  int          consumed;
  int          since;
  int          last_fire;
  int          last_rise;
  logic [31:0] tgt;

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0; imem_resp_err = 1'b0; inst_ready = 1'b0;
    exp_pc = RESET_PC; exp_inv_next = 1'b0; prev_req_stall = 1'b0; prev_valid = 1'b0;
    guard = 1'b0; consumed = 0; since = 0; last_fire = -100; last_rise = -1;
    #1 chk_reset_outputs("rst_init");
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      if (rst) begin
        rst = 1'b0;
        guard = 1'b1;
      end else begin
        guard = 1'b0;
      end
      directed = (cyc < N_DIR);

      // memory response side
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      imem_resp_err   = 1'($urandom_range(1));
      if (q_addr.size() != 0) begin
        if (q_dly[0] == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_data(q_addr[0]);
          imem_resp_err   = mem_err(q_addr[0]);
          void'(q_addr.pop_front());
          void'(q_dly.pop_front());
        end else begin
          q_dly[0] = q_dly[0] - 1;
        end
      end else if (guard || $urandom_range(7) == 0) begin
        imem_resp_valid = 1'b1;  // stray response with nothing outstanding
      end

      imem_req_ready = directed ? 1'b1 : ($urandom_range(9) < 7);
      inst_ready     = directed ? 1'b1 : ($urandom_range(9) < 7);
      redirect_valid = !directed && !guard && ($urandom_range(19) == 0);
      case ($urandom_range(7))
        0:       tgt = (RESET_PC + {22'd0, 8'($urandom_range(255)), 2'b00})
                       | {30'd0, 2'($urandom_range(3, 1))};
        1:       tgt = 32'hFFFF_FFF8;
        default: tgt = RESET_PC + {22'd0, 8'($urandom_range(255)), 2'b00};
      endcase
      redirect_pc = tgt;

      #1;
      if (guard) begin
        chk("idle_valid", {31'd0, inst_valid}, 32'd0);
        chk("idle_req", {31'd0, imem_req_valid}, 32'd0);
      end
      if (exp_inv_next) begin
        chk("drop_valid", {31'd0, inst_valid}, 32'd0);
        chk("drop_cmd", inst_cmd, NOP_CMD);
      end
      if (inst_valid) begin
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst_cmd", inst_cmd, (exp_pc[1:0] == 2'b00) ? mem_data(exp_pc) : NOP_CMD);
        chk("inst_fault", {31'd0, inst_fault},
            {31'd0, (exp_pc[1:0] != 2'b00) || mem_err(exp_pc)});
      end
      if (imem_req_valid) begin
        chk("req_addr", imem_req_addr, exp_pc);
        chk("req_outstanding", 32'(q_addr.size()), 32'd0);
        chk("req_while_valid", {31'd0, inst_valid}, 32'd0);
      end
      if (prev_req_stall)
        chk("req_hold", {31'd0, imem_req_valid}, 32'd1);
      if (directed && inst_valid && !prev_valid) begin
        chk("latency", 32'(cyc - last_fire), 32'd2);
        if (last_rise >= 0) chk("spacing", 32'(cyc - last_rise), 32'd3);
        last_rise = cyc;
      end

      // events at the coming rising edge
      fire = imem_req_valid && imem_req_ready;
      hs   = inst_valid && inst_ready;
      if (fire) begin
        q_addr.push_back(imem_req_addr);
        q_dly.push_back(directed ? 0 : int'($urandom_range(2)));
        last_fire = cyc;
      end
      exp_inv_next = 1'b0;
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        exp_inv_next = inst_valid;
      end else if (hs) begin
        exp_pc = exp_pc + 32'd4;
        exp_inv_next = 1'b1;
        consumed++;
        since = 0;
      end
      prev_req_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_valid = inst_valid;
      since++;
      chk("progress", {31'd0, since > 200}, 32'd0);

      // occasional asynchronous reset in the middle of a cycle
      if (!directed && $urandom_range(299) == 0) begin
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_async");
        q_addr.delete();
        q_dly.delete();
        exp_pc = RESET_PC;
        exp_inv_next = 1'b0;
        prev_req_stall = 1'b0;
        prev_valid = 1'b0;
        since = 0;
        @(posedge clk);
        #1 chk_reset_outputs("rst_held");
      end
    end

    chk("consumed_enough", {31'd0, consumed > 200}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
